mem_dump_uart_tx: RTL
=====================

Name: mem_dump_uart_tx

Overview:
- Read-side master for the memory's byte-wide dump port; drives dump_addr and consumes dump_data.
- On a start pulse, walks a fixed byte range and serialises each byte onto a UART line: 8N1, LSB first, no parity.
- Sits between the data memory's dump port and the board's UART TX pin, so memory contents can be inspected after a RISC-V/matmul run.

Parameters:
- ADDR_W, 12, dump byte-address width; addresses wrap modulo 2^ADDR_W.
- START_ADDR, 0, first byte address dumped.
- BYTE_COUNT, 4096, number of bytes sent per dump; legal range 1..2^ADDR_W.
- CLKS_PER_BIT, 868, clk_i cycles per UART bit (100 MHz / 115200); minimum 2.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  level sampled in IDLE; high starts a dump.
- dump_addr  out  ADDR_W  byte address to the memory dump port.
- dump_data  in  8  byte from the memory dump port; combinational, valid in the same cycle as dump_addr.
- uart_tx_o  out  1  serial line, idle high.
- busy_o  out  1  high from start acceptance until the last stop bit completes.
- done_o  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame) forces the following:
  - state = IDLE, uart_tx_o = 1, busy_o = 0, done_o = 0, dump_addr = START_ADDR.
  - bit, baud and byte counters cleared.
- All outputs are registered.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - uart_tx_o = 1, dump_addr = START_ADDR.
  - start_i = 1 at an edge → LOAD, busy_o <= 1, byte counter <= 0.
- LOAD (exactly 1 cycle):
  - Shift register <= dump_data for the current dump_addr.
  - uart_tx_o <= 0, baud counter <= 0 → START.
- START: line low for exactly CLKS_PER_BIT cycles → DATA, bit index 0, uart_tx_o <= shift[0].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, then the register shifts right and the next bit is driven.
  - After bit 7's period → STOP, uart_tx_o <= 1.
- STOP: high for CLKS_PER_BIT cycles, then one of the following:
  - If byte counter == BYTE_COUNT-1 → IDLE, busy_o <= 0, done_o <= 1 for one cycle, dump_addr <= START_ADDR.
  - Otherwise → LOAD, byte counter +1, dump_addr <= dump_addr + 1 (wraps from 2^ADDR_W-1 to 0).
- Timing:
  - Per-byte period is 10*CLKS_PER_BIT + 1 cycles; there is no extra idle between bytes beyond the LOAD cycle.
  - A full dump from LOAD entry to IDLE takes BYTE_COUNT*(10*CLKS_PER_BIT+1) cycles.
  - done_o rises on the same edge that busy_o falls.
- start_i is ignored in every state except IDLE, with no queuing.
  - start_i held high continuously re-triggers a new dump on the first IDLE cycle after done_o.
- dump_data is sampled only in LOAD; memory writes during a byte's transmission do not affect that byte.
- Baud counter width: ceil(log2(CLKS_PER_BIT)). Byte counter width: ADDR_W+1.

Test Plan:
- Basic dump:
  - Stimulus: CLKS_PER_BIT=4, START_ADDR=0, BYTE_COUNT=4, memory word0=0x48656C6C, 1-cycle start_i pulse.
  - Required: decoded UART bytes are 0x6C,0x6C,0x65,0x48; dump_addr sequence is 0,1,2,3; done_o pulses once after 4*41=164 cycles from LOAD entry.
- Bit timing:
  - Stimulus: same config.
  - Required: start bit low exactly 4 cycles; each data bit 4 cycles LSB first (0x6C → 0,0,1,1,0,1,1,0); stop bit high 4 cycles; uart_tx_o high at all times in IDLE.
- Address wrap:
  - Stimulus: START_ADDR=0xFFE, BYTE_COUNT=4.
  - Required: dump_addr visits 0xFFE,0xFFF,0x000,0x001; transmitted bytes match memory at those addresses; dump_addr returns to 0xFFE in IDLE.
- Start while busy:
  - Stimulus: pulse start_i again during byte 2.
  - Required: no restart; exactly BYTE_COUNT bytes sent; a single done_o pulse. Holding start_i high starts a second dump one cycle after done_o.
- Reset mid-frame:
  - Stimulus: assert reset_i during DATA bit 3, asynchronously between edges.
  - Required: uart_tx_o = 1, busy_o = 0, done_o = 0, dump_addr = START_ADDR immediately. After release, a new start_i gives a full, correct dump from START_ADDR.
- Single-byte dump:
  - Stimulus: BYTE_COUNT=1, CLKS_PER_BIT=2, memory byte 0xA5 at START_ADDR.
  - Required: frame is 0,1,0,1,0,0,1,0,1,1 at 2 cycles per bit; busy_o high for 21 cycles (LOAD + 20 bit cycles, excluding the acceptance edge); done_o is one pulse.

Source files
------------

// File: rtl/mem_dump_uart_tx.sv
// Walks a fixed byte range of the memory dump port and sends each byte out as a UART 8N1 frame.
// Dump bytes go out back to back. The only gap between frames is a single LOAD cycle that fetches the next byte.
module mem_dump_uart_tx #(
    parameter int ADDR_W       = 12,
    parameter int START_ADDR   = 0,
    parameter int BYTE_COUNT   = 4096,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] dump_addr,
    input  logic [7:0]        dump_data,
    output logic              uart_tx_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  BYTE_LAST  = CNT_W'(BYTE_COUNT - 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [CNT_W-1:0]  byte_q, byte_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] addr_d;
    logic              tx_d, busy_d, done_d;
    logic              baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        // NOTE: every next value gets a default before the case, so no path can infer a latch.
        state_d = state_q;
        baud_d  = baud_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        addr_d  = dump_addr;
        tx_d    = uart_tx_o;
        busy_d  = busy_o;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                addr_d = FIRST_ADDR;
                busy_d = 1'b0;
                if (start_i) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    byte_d  = '0;
                end
            end
            LOAD: begin
                // The memory port is combinational, so dump_data belongs to the current dump_addr.
                shift_d = dump_data;
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    if (byte_q == BYTE_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        addr_d  = FIRST_ADDR;
                    end else begin
                        state_d = LOAD;
                        byte_d  = byte_q + 1'b1;
                        addr_d  = dump_addr + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            shift_q   <= '0;
            dump_addr <= FIRST_ADDR;
            uart_tx_o <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all registers update together from pre-edge values.
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            dump_addr <= addr_d;
            uart_tx_o <= tx_d;
            busy_o    <= busy_d;
            done_o    <= done_d;
        end
    end
endmodule
